// File: rtl/ahb_gpio_irq_pkg.sv
// Shared definitions for the AHB GPIO slave with edge interrupts:
// register offsets (word index), HTRANS encodings and the address decoder.
// Optional build macro: AHB_GPIO_IRQ_LEVEL_EN adds IRQ_LEVEL at 0x1C and
// moves IRQ_STATUS to 0x20.
package ahb_gpio_irq_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [REG_IDX_W-1:0] GPIO_REG_DATA   = 4'd0;
  localparam logic [REG_IDX_W-1:0] GPIO_REG_DIR    = 4'd1;
  localparam logic [REG_IDX_W-1:0] GPIO_REG_SET    = 4'd2;
  localparam logic [REG_IDX_W-1:0] GPIO_REG_CLR    = 4'd3;
  localparam logic [REG_IDX_W-1:0] GPIO_REG_IRQ_EN = 4'd4;
  localparam logic [REG_IDX_W-1:0] GPIO_REG_RISE   = 4'd5;
  localparam logic [REG_IDX_W-1:0] GPIO_REG_FALL   = 4'd6;
`ifdef AHB_GPIO_IRQ_LEVEL_EN
  localparam logic [REG_IDX_W-1:0] GPIO_REG_LEVEL  = 4'd7;
  localparam logic [REG_IDX_W-1:0] GPIO_REG_STATUS = 4'd8;
`else
  localparam logic [REG_IDX_W-1:0] GPIO_REG_STATUS = 4'd7;
`endif

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Byte address to register word index; the level build decodes one more bit.
  function automatic logic [REG_IDX_W-1:0] reg_index(input logic [11:0] addr);
`ifdef AHB_GPIO_IRQ_LEVEL_EN
    return addr[5:2];
`else
    return {1'b0, addr[4:2]};
`endif
  endfunction

endpackage

// File: rtl/ahb_gpio_irq_sync.sv
// Input conditioning for the GPIO pins: SYNC_STAGES-deep synchronizer,
// one-cycle delayed copy (prev) and raw rising/falling edge strobes.
module ahb_gpio_sync
  import ahb_gpio_irq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Newest sample sits in the low WIDTH bits, the oldest (sync_o) on top.
  logic [SYNC_STAGES*WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  // Shift the pin samples along the chain and keep the previous synced value.
  always_comb begin
    chain_d = {chain_q[(SYNC_STAGES-1)*WIDTH-1:0], pin_i};
    prev_d  = sync_o;
  end

  // Synchronizer and prev flops, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[SYNC_STAGES*WIDTH-1 -: WIDTH];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/ahb_gpio_irq.sv
// Zero-wait AHB-Lite GPIO slave: WIDTH pins with direction, atomic SET/CLR,
// synchronized inputs and per-pin rising/falling edge interrupt capture.
// Optional build macro: AHB_GPIO_IRQ_LEVEL_EN (level-sensitive status bits).
module ahb_gpio_irq
  import ahb_gpio_irq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK_I,
  input  logic             HRESET_I,
  input  logic [WIDTH-1:0] PORT_I,
  output logic [WIDTH-1:0] PORT_O,
  output logic [WIDTH-1:0] DIR_O,
  output logic             IRQ_O,
  input  logic             HSEL_I,
  input  logic             HREADY_I,
  input  logic [1:0]       HTRANS_I,
  input  logic [2:0]       HSIZE_I,
  input  logic             HWRITE_I,
  input  logic [11:0]      HADDR_I,
  input  logic [31:0]      HRDATA_I,
  output logic [31:0]      HWDATA_O,
  output logic             HRESP_O,
  output logic             HREADY_O
);

  // Bus handshake: a transfer is taken in its address phase when
  // HSEL_I & HREADY_I & HTRANS_I[1]. Read data is registered on that same
  // edge and held through the data phase; write data (HRDATA_I) is applied
  // on the next edge. HREADY_O is always 1, so no phase is ever stretched.

  localparam int                 GUARD_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_in, rise, fall;

  logic                 valid_q, valid_d;
  logic                 write_q, write_d;
  logic [REG_IDX_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     dir_q, dir_d;
  logic [WIDTH-1:0]     irq_en_q, irq_en_d;
  logic [WIDTH-1:0]     rise_en_q, rise_en_d;
  logic [WIDTH-1:0]     fall_en_q, fall_en_d;
  logic [WIDTH-1:0]     status_q, status_d;
  logic                 irq_q, irq_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [GUARD_W-1:0]   guard_q, guard_d;
`ifdef AHB_GPIO_IRQ_LEVEL_EN
  logic [WIDTH-1:0]     level_q, level_d;
`endif

  logic                 accept;
  logic                 do_write;
  logic [WIDTH-1:0]     wdata;
  logic [WIDTH-1:0]     w1c;
  logic [WIDTH-1:0]     edge_set;
  logic [WIDTH-1:0]     set_bits;
  logic [REG_IDX_W-1:0] rd_idx;
  logic [31:0]          rd_val;
  logic                 unused_ok;

  ahb_gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (HCLK_I),
    .rst_i  (HRESET_I),
    .pin_i  (PORT_I),
    .sync_o (sync_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Next-state for bus pipeline, registers, status, interrupt and read data.
  always_comb begin
    accept    = HSEL_I & HREADY_I & HTRANS_I[1];
    do_write  = valid_q & write_q & HREADY_I;
    wdata     = HRDATA_I[WIDTH-1:0];

    valid_d   = valid_q;
    write_d   = write_q;
    addr_d    = addr_q;
    if (HREADY_I) begin
      valid_d = accept;
      write_d = HWRITE_I;
      addr_d  = reg_index(HADDR_I);
    end

    data_d    = data_q;
    dir_d     = dir_q;
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
`ifdef AHB_GPIO_IRQ_LEVEL_EN
    level_d   = level_q;
`endif
    if (do_write) begin
      case (addr_q)
        GPIO_REG_DATA:   data_d    = wdata;
        GPIO_REG_DIR:    dir_d     = wdata;
        GPIO_REG_SET:    data_d    = data_q | wdata;
        GPIO_REG_CLR:    data_d    = data_q & ~wdata;
        GPIO_REG_IRQ_EN: irq_en_d  = wdata;
        GPIO_REG_RISE:   rise_en_d = wdata;
        GPIO_REG_FALL:   fall_en_d = wdata;
`ifdef AHB_GPIO_IRQ_LEVEL_EN
        GPIO_REG_LEVEL:  level_d   = wdata;
`endif
        GPIO_REG_STATUS: w1c       = wdata;
        default: ;
      endcase
    end

    // Edges are ignored until the synchronizer has been refilled after reset.
    guard_d  = (guard_q == GUARD_MAX) ? guard_q : guard_q + 1'b1;
    edge_set = (guard_q == GUARD_MAX) ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
`ifdef AHB_GPIO_IRQ_LEVEL_EN
    set_bits = (~level_q & edge_set)
             | (level_q & ((sync_in & rise_en_q) | (~sync_in & fall_en_q)));
`else
    set_bits = edge_set;
`endif
    // Set terms come last so an edge beats a W1C on the same edge.
    status_d = (status_q & ~w1c) | set_bits;
    irq_d    = |(status_q & irq_en_q);

    // Reads see the post-write register values (write forwarding).
    rd_idx = reg_index(HADDR_I);
    rd_val = '0;
    case (rd_idx)
      GPIO_REG_DATA:   rd_val[WIDTH-1:0] = (sync_in & ~dir_d) | (data_d & dir_d);
      GPIO_REG_DIR:    rd_val[WIDTH-1:0] = dir_d;
      GPIO_REG_IRQ_EN: rd_val[WIDTH-1:0] = irq_en_d;
      GPIO_REG_RISE:   rd_val[WIDTH-1:0] = rise_en_d;
      GPIO_REG_FALL:   rd_val[WIDTH-1:0] = fall_en_d;
`ifdef AHB_GPIO_IRQ_LEVEL_EN
      GPIO_REG_LEVEL:  rd_val[WIDTH-1:0] = level_d;
`endif
      GPIO_REG_STATUS: rd_val[WIDTH-1:0] = status_d;
      default: ;
    endcase
    rdata_d = (accept & ~HWRITE_I) ? rd_val : rdata_q;
  end

  // All state flops with synchronous active-high reset.
  always_ff @(posedge HCLK_I) begin
    if (HRESET_I) begin
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      dir_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      guard_q   <= '0;
`ifdef AHB_GPIO_IRQ_LEVEL_EN
      level_q   <= '0;
`endif
    end else begin
      valid_q   <= valid_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      irq_en_q  <= irq_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      guard_q   <= guard_d;
`ifdef AHB_GPIO_IRQ_LEVEL_EN
      level_q   <= level_d;
`endif
    end
  end

  assign PORT_O    = data_q;
  assign DIR_O     = dir_q;
  assign IRQ_O     = irq_q;
  assign HWDATA_O  = rdata_q;
  assign HRESP_O   = 1'b0;
  assign HREADY_O  = 1'b1;

  // Transfer size, unused address bits and upper write-data bits are don't-care.
  assign unused_ok = ^{HSIZE_I, HADDR_I, HRDATA_I, HTRANS_I[0]};

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Directed bench for ahb_gpio_irq: an 8-pin instance plus a 4-pin instance
// on the same bus for the width-masking check.
module tb_ahb_gpio_irq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  port_i = '0;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [11:0] haddr = '0;
  logic [31:0] hrdata = '0;

  logic [7:0]  port_o8, dir_o8;
  logic        irq8, hresp8, hready8;
  logic [31:0] hwdata8;
  logic [3:0]  port_o4, dir_o4;
  logic        irq4, hresp4, hready4;
  logic [31:0] hwdata4;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd8, rd4;

  ahb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .HCLK_I(clk), .HRESET_I(rst), .PORT_I(port_i), .PORT_O(port_o8), .DIR_O(dir_o8),
    .IRQ_O(irq8), .HSEL_I(hsel), .HREADY_I(1'b1), .HTRANS_I(htrans), .HSIZE_I(3'b010),
    .HWRITE_I(hwrite), .HADDR_I(haddr), .HRDATA_I(hrdata), .HWDATA_O(hwdata8),
    .HRESP_O(hresp8), .HREADY_O(hready8)
  );

  ahb_gpio_irq #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .HCLK_I(clk), .HRESET_I(rst), .PORT_I(port_i[3:0]), .PORT_O(port_o4), .DIR_O(dir_o4),
    .IRQ_O(irq4), .HSEL_I(hsel), .HREADY_I(1'b1), .HTRANS_I(htrans), .HSIZE_I(3'b010),
    .HWRITE_I(hwrite), .HADDR_I(haddr), .HRDATA_I(hrdata), .HWDATA_O(hwdata4),
    .HRESP_O(hresp4), .HREADY_O(hready4)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: new address phase plus write data for the previous one.
  task automatic bus_cycle(input logic v, input logic w, input logic [11:0] a,
                           input logic [31:0] wd);
    @(posedge clk); #1;
    hsel   = v;
    htrans = v ? 2'b10 : 2'b00;
    hwrite = w;
    haddr  = a;
    hrdata = wd;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] wd);
    bus_cycle(1'b1, 1'b1, a, 32'h0);
    bus_cycle(1'b0, 1'b0, 12'h0, wd);
    bus_cycle(1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d8, output logic [31:0] d4);
    bus_cycle(1'b1, 1'b0, a, 32'h0);
    bus_cycle(1'b0, 1'b0, 12'h0, 32'h0);
    @(negedge clk);
    d8 = hwdata8;
    d4 = hwdata4;
  endtask

  task automatic expect_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d8, d4;
    exp_q.push_back(exp);
    bus_read(a, d8, d4);
    check(tag, d8, exp_q.pop_front());
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hwdata", hwdata8, 32'h0);
    check("rst_irq", {31'h0, irq8}, 32'h0);
    check("rst_hready", {31'h0, hready8}, 32'h1);
    check("rst_hresp", {31'h0, hresp8}, 32'h0);
    check("rst_port_o", {24'h0, port_o8}, 32'h0);
    check("rst_dir_o", {24'h0, dir_o8}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      expect_read($sformatf("rst_reg%0d", i), 12'(i * 4), 32'h0);
    end

    // Direction-mixed DATA read
    port_i = 8'h3C;
    bus_write(12'h04, 32'h0000_00F0);
    bus_write(12'h00, 32'h0000_00A5);
    @(negedge clk);
    check("data_port_o", {24'h0, port_o8}, 32'hA5);
    expect_read("data_mixed", 12'h00, 32'hAC);

    // Back-to-back DATA/SET/CLR with a forwarded read right behind
    bus_write(12'h04, 32'h0000_00FF);
    bus_cycle(1'b1, 1'b1, 12'h00, 32'h0);
    bus_cycle(1'b1, 1'b1, 12'h08, 32'h0000_000F);
    bus_cycle(1'b1, 1'b1, 12'h0C, 32'h0000_0030);
    bus_cycle(1'b1, 1'b0, 12'h00, 32'h0000_0003);
    bus_cycle(1'b0, 1'b0, 12'h00, 32'h0);
    @(negedge clk);
    check("setclr_port_o", {24'h0, port_o8}, 32'h3C);
    check("setclr_fwd_read", hwdata8, 32'h3C);

    // Rising edge on pin 0: status after 3 edges, IRQ_O one edge later
    bus_write(12'h14, 32'h1);
    bus_write(12'h10, 32'h1);
    @(posedge clk); #1 port_i = 8'h3D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("irq_not_yet", {31'h0, irq8}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("irq_raised", {31'h0, irq8}, 32'h1);
    expect_read("status_rise", 12'h1C, 32'h01);
    bus_write(12'h1C, 32'h1);
    @(negedge clk);
    check("irq_lag_w1c", {31'h0, irq8}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("irq_cleared", {31'h0, irq8}, 32'h0);
    expect_read("status_w1c", 12'h1C, 32'h00);

    // Pins high through reset release, rise enable written at once
    @(posedge clk); #1;
    rst = 1'b1;
    port_i = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 12'h14;
    bus_cycle(1'b0, 1'b0, 12'h0, 32'h0000_00FF);
    bus_cycle(1'b0, 1'b0, 12'h0, 32'h0);
    repeat (6) @(posedge clk);
    expect_read("guard_rise_en", 12'h14, 32'hFF);
    expect_read("guard_status", 12'h1C, 32'h00);

    // Falling edge on pin 2 coinciding with W1C of bit 2
    bus_write(12'h18, 32'h04);
    @(posedge clk); #1 port_i = 8'hFB;
    repeat (5) @(posedge clk);
    expect_read("fall_status", 12'h1C, 32'h04);
    @(posedge clk); #1 port_i = 8'hFF;
    repeat (5) @(posedge clk);
    @(posedge clk); #1 port_i = 8'hFB;
    bus_cycle(1'b1, 1'b1, 12'h1C, 32'h0);
    bus_cycle(1'b0, 1'b0, 12'h0, 32'h04);
    bus_cycle(1'b0, 1'b0, 12'h0, 32'h0);
    expect_read("edge_beats_w1c", 12'h1C, 32'h04);
    bus_write(12'h1C, 32'h04);
    expect_read("plain_w1c", 12'h1C, 32'h00);

    // Bits above WIDTH ignored on write, read as 0
    bus_write(12'h04, 32'hFFFF_FFFF);
    bus_read(12'h04, rd8, rd4);
    check("dir_w8", rd8, 32'h0000_00FF);
    check("dir_w4", rd4, 32'h0000_000F);
    check("dir_o_w4", {28'h0, dir_o4}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_gpio_irq.md
Name: ahb_gpio_irq

Overview:
Parametrised successor of the 8-bit AHB GPIO slave. Provides WIDTH pins, with per-pin direction, atomic set/clear of output data, an input synchronizer, and per-pin rising/falling-edge interrupt capture. The block is a zero-wait-state AHB-Lite slave on the peripheral bus, and drives one combined interrupt line to the interrupt controller.

Parameters:
WIDTH, 8, number of GPIO pins (1..32)
SYNC_STAGES, 2, flip-flop stages on PORT_I before use (2..4)

Ports:
HCLK_I  in  1  bus clock; all logic on rising edge
HRESET_I  in  1  synchronous, active-high reset
PORT_I  in  WIDTH  pin input values (asynchronous)
PORT_O  out  WIDTH  output data register
DIR_O  out  WIDTH  direction, 1 = output
IRQ_O  out  1  registered OR of (IRQ_STATUS & IRQ_EN)
HSEL_I  in  1  slave select
HREADY_I  in  1  bus ready (previous transfer done)
HTRANS_I  in  2  transfer type; bit1 = NONSEQ/SEQ
HSIZE_I  in  3  ignored; every access is treated as a 32-bit word
HWRITE_I  in  1  1 = write
HADDR_I  in  12  byte address; [4:2] selects the register
HRDATA_I  in  32  write data from master (codebase naming)
HWDATA_O  out  32  read data to master (codebase naming)
HRESP_O  out  1  constant 0 (OKAY)
HREADY_O  out  1  constant 1 (zero wait)

Behaviour:
- Clock and reset: one clock, HCLK_I. Reset is synchronous and active-high on HRESET_I; every register is cleared on the HCLK_I edge where HRESET_I = 1.
- Transfer acceptance: a transfer is accepted when HSEL_I & HREADY_I & HTRANS_I[1]. The address phase registers the address (HADDR_I[4:2]), the write flag and a valid flag.
- Register map (offsets):
  - 0x00 DATA: write loads data. Read returns (sync_in & ~dir) | (data & dir).
  - 0x04 DIR: read/write.
  - 0x08 SET: write-1-to-set data bits; reads 0.
  - 0x0C CLR: write-1-to-clear data bits; reads 0.
  - 0x10 IRQ_EN: read/write.
  - 0x14 IRQ_RISE: read/write per-pin rising-edge enable.
  - 0x18 IRQ_FALL: read/write per-pin falling-edge enable.
  - 0x1C IRQ_STATUS: read; write-1-to-clear.
- Writes take effect on the HCLK_I edge ending the data phase, using HRDATA_I[WIDTH-1:0]. Bits at or above WIDTH are ignored on write and read as 0.
- Reads: HWDATA_O is registered at the end of the address phase and is valid for the whole data phase. If the read address matches a write completing on the same edge, the read returns the post-write value (forwarding is mandatory). A non-selected or idle cycle holds HWDATA_O.
- Reset values: PORT_O = 0, DIR_O = 0, IRQ_O = 0, HWDATA_O = 0. IRQ_EN, IRQ_RISE, IRQ_FALL and IRQ_STATUS are 0. The synchronizer and previous-sample registers are 0.
- Input path: PORT_I passes through SYNC_STAGES flops to give sync_in. prev is sync_in delayed by one cycle.
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
  - Pin-to-status latency is SYNC_STAGES+1 cycles; IRQ_O follows one cycle later.
- Startup guard: a counter of width clog2(SYNC_STAGES+2) is reset to 0 and counts to SYNC_STAGES+1, then saturates. Edge capture is masked until it saturates, so pins that are already high at reset release give no spurious edge. Reset asserted mid-count restarts the count.
- Status update per bit: status <= (status & ~w1c) | (rise & IRQ_RISE) | (fall & IRQ_FALL).
  - A new edge in the same cycle as its W1C wins, so the bit stays set.
  - Edges are captured on every pin regardless of DIR; IRQ_EN masks IRQ_O only, not status.
- Atomicity: SET and CLR are single-cycle read-modify-write inside the block, with no master read needed. A new DATA/SET/CLR write is applied on top of the previous write's result, so back-to-back writes are all honoured.

Optional Feature:
Macro: AHB_GPIO_IRQ_LEVEL_EN.
- Defined: the map gains 0x1C IRQ_LEVEL, and IRQ_STATUS moves to 0x20 (HADDR_I[5:2] decoded). For a pin with IRQ_LEVEL = 1, status is set every cycle while sync_in = 1 and IRQ_RISE = 1, or while sync_in = 0 and IRQ_FALL = 1. W1C on such a bit has no effect while its level persists.
- Undefined: edge-only behaviour as above. Only [4:2] is decoded, and 0x1C is IRQ_STATUS.

Decomposition:
- defs.vh: register offset localparams (GPIO_REG_DATA ... GPIO_REG_STATUS) and the AHB HTRANS encodings.
- Sub-module ahb_gpio_sync: WIDTH-wide SYNC_STAGES synchronizer plus prev register and rise/fall outputs, instantiated once.

Test Plan:
- Reset, then read all registers → all read 0, IRQ_O = 0, HREADY_O = 1, HRESP_O = 0.
- WIDTH = 8: write DIR = 0xF0, DATA = 0xA5 with PORT_I = 0x3C → PORT_O = 0xA5; DATA reads 0xAC.
- DATA = 0x0F, SET 0x30, then CLR 0x03 back-to-back → PORT_O = 0x3C after the last write; a read of DATA (DIR = 0xFF) in the immediately following address phase returns 0x3C.
- IRQ_RISE = 0x01, IRQ_EN = 0x01, PORT_I[0] 0→1 → IRQ_STATUS = 0x01 after 3 cycles (SYNC_STAGES = 2); IRQ_O = 1 one cycle later. W1C 0x01 → IRQ_O = 0.
- PORT_I = 0xFF held through reset release, with IRQ_RISE = 0xFF written immediately → IRQ_STATUS stays 0.
- Falling edge on pin 2 arriving on the same edge as W1C 0x04 → IRQ_STATUS[2] = 1 afterwards. Then, with WIDTH = 4, write 0xFFFFFFFF to DIR → reads 0x0000000F.
